// File: rtl/irq_pending_enc_if.sv
// Index handshake bundle for irq_pending_enc.
// master: producer of out_id/out_valid; slave: consumer driving out_ready.
interface irq_pending_enc_if #(
    parameter int unsigned WIDTH_W = 5
);
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_W-1:0] out_id;

    modport master (output out_valid, output out_id, input out_ready);
    modport slave  (input out_valid, input out_id, output out_ready);
endinterface

// File: rtl/irq_pending_enc.sv
// irq_pending_enc: captures rising edges of request lines into sticky
// pending bits, masks them and hands out the highest eligible index one at
// a time over a valid/ready handshake.
// Optional: define IRQ_LOST_CNT_EN to add lost_cnt, a saturating count of
// cycles where an edge hit an already-pending bit.
module irq_pending_enc #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned WIDTH_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     irq_in,
    input  logic [WIDTH-1:0]     mask,
    output logic [WIDTH-1:0]     pending,
`ifdef IRQ_LOST_CNT_EN
    output logic [15:0]          lost_cnt,
`endif
    irq_pending_enc_if.master    out_if
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_irq_prev;
    logic [WIDTH-1:0]   r_pending;
    logic [WIDTH_W-1:0] r_out_id;

    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_elig;
    logic [WIDTH_W-1:0] w_sel;
    logic               w_any;
    logic               w_hs;
    logic               w_load;

    assign w_rise = irq_in & ~r_irq_prev;
    assign w_elig = r_pending & ~mask;
    assign w_hs   = (r_state == S_PRESENT) && out_if.out_ready;
    assign w_clr  = w_hs ? ({{(WIDTH-1){1'b0}}, 1'b1} << r_out_id) : '0;

    assign pending          = r_pending;
    assign out_if.out_valid = (r_state == S_PRESENT);
    assign out_if.out_id    = r_out_id;

    // Highest set index of the eligible vector (later hits overwrite earlier).
    always_comb begin
        w_sel = '0;
        w_any = |w_elig;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_elig[i]) begin
                w_sel = WIDTH_W'(i);
            end
        end
    end

    // Next-state: grant from IDLE when enabled and something is eligible.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ena && w_any) begin
                    w_next_state = S_PRESENT;
                    w_load       = 1'b1;
                end
            end
            S_PRESENT: begin
                if (out_if.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Edge capture, pending update (a new edge beats the clear) and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_out_id   <= '0;
            r_state    <= S_IDLE;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_state    <= w_next_state;
            if (w_load) begin
                r_out_id <= w_sel;
            end
        end
    end

`ifdef IRQ_LOST_CNT_EN
    logic [15:0] r_lost_cnt;
    logic        w_lost_hit;

    assign w_lost_hit = |(w_rise & r_pending & ~w_clr);
    assign lost_cnt   = r_lost_cnt;

    // Saturating count of cycles in which an edge coalesced into a pending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lost_cnt <= '0;
        end else if (w_lost_hit && (r_lost_cnt != 16'hFFFF)) begin
            r_lost_cnt <= r_lost_cnt + 16'd1;
        end
    end
`endif

endmodule
